addsub_serial: RTL and testbench



---
 rtl/addsub_pkg.sv | 30 +++
 rtl/addsub_digit.sv | 27 ++
 rtl/addsub_serial.sv | 156 +++++++++++++++
 tb/tb_addsub_serial.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared state type and elaboration helpers for the digit-serial adder/subtractor.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    localparam int SAT_W_MAX = 64;

    // A return of 0 flags a digit size that does not tile the operand width.
    function automatic int calc_ndig(input int width, input int digit);
        if (digit < 1 || width < 2 || (width % digit) != 0) begin
            return 0;
        end
        return width / digit;
    endfunction

    function automatic logic [SAT_W_MAX-1:0] sat_max(input int width);
        return (SAT_W_MAX'(1) << (width - 1)) - SAT_W_MAX'(1);
    endfunction

    function automatic logic [SAT_W_MAX-1:0] sat_min(input int width);
        return SAT_W_MAX'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple-carry adder slice built from per-bit full adders.
// Latency: purely combinational.
// Backpressure: none; the caller sequences every digit.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
        assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end

    assign cout  = c[DIGIT];
    // Carry into the top bit: only meaningful on the last digit, for overflow.
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub with flags; ADDSUB_SAT_EN clamps on overflow.
// Latency: out_valid rises NDIG edges after the accepting edge; no overlap between ops.
// Backpressure: result and flags held while out_valid & !out_ready; in_ready low until handshake.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             cout,
    output logic             zero,
    output logic             neg
);
    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    if (NDIG == 0) begin : g_bad_cfg
        $error("addsub_serial: WIDTH=%0d must be >= 2 and a multiple of DIGIT=%0d", WIDTH, DIGIT);
    end

`ifdef ADDSUB_SAT_EN
    if (WIDTH > SAT_W_MAX) begin : g_bad_sat
        $error("addsub_serial: saturation supports WIDTH up to %0d", SAT_W_MAX);
    end
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

    addsub_state_t    state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [WIDTH-1:0] acc_nxt, res;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovfl_q, ovfl_d, cout_q, cout_d, zero_q, zero_d, neg_q, neg_d;
    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_cout, dig_cmsb;

    assign dig_a = opa_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign dig_b = opb_q[int'(cnt_q) * DIGIT +: DIGIT];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d   (dig_a),
        .b_d   (dig_b),
        .cin   (carry_q),
        .s_d   (dig_s),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // Completed result as it would stand once the current digit lands.
    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[int'(cnt_q) * DIGIT +: DIGIT] = dig_s;
        res = acc_nxt;
`ifdef ADDSUB_SAT_EN
        if (dig_cmsb ^ dig_cout) begin
            res = dig_cout ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovfl_d  = ovfl_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_nxt;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    cout_d  = dig_cout;
                    ovfl_d  = dig_cmsb ^ dig_cout;
                    sum_d   = res;
                    zero_d  = (res == '0);
                    neg_d   = res[WIDTH-1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovfl_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovfl_q  <= ovfl_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign ovfl      = ovfl_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: directed corner cases plus random ops vs. an integer model.
module tb_addsub_serial;
    localparam int W    = 16;
    localparam int D    = 4;
    localparam int NDIG = W / D;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));
    localparam int UMAX = (1 << W) - 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         ovfl;
        logic         cout;
        logic         zero;
        logic         neg;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         ovfl, cout, zero, neg;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovfl      (ovfl),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Arithmetic on plain integers: true signed result, then wrap or clamp.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
        exp_t e;
        int sa = int'($signed(ta));
        int sv = int'($signed(tbv));
        int tru = ts ? (sa - sv) : (sa + sv);
        e.ovfl = (tru > SMAX) || (tru < SMIN);
        e.cout = ts ? (ta >= tbv) : ((int'(ta) + int'(tbv)) > UMAX);
        e.sum  = tru[W-1:0];
`ifdef ADDSUB_SAT_EN
        if (e.ovfl) e.sum = (tru > 0) ? W'(SMAX) : W'(SMIN);
`endif
        e.zero = (e.sum == '0);
        e.neg  = e.sum[W-1];
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                         input bit hold, output int acc);
        exp_t e;
        int w = 0;
        a = ta; b = tbv; sub = ts; in_valid = 1'b1;
        while (!in_ready && w < 200) begin
            step();
            w++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", w);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        e = model(ta, tbv, ts);
        e.acc_cyc = cyc + 1;
        acc = e.acc_cyc;
        sb.push_back(e);
        step();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 300) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            w++;
        end
        out_ready = 1'b1;
        if (sb.size() != 0 || out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d results pending after %0d cycles, expected 0", sb.size(), w);
        end
    endtask

    // Monitor: compares the head of the scoreboard on every cycle a result is presented.
    initial begin : monitor
        exp_t e;
        bit   prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: sum=0x%0h presented with no operation outstanding", sum);
                end else begin
                    e = sb[0];
                    if (!prev_vld) chk("latency", 32'(cyc - e.acc_cyc), 32'(NDIG));
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("ovfl", 32'(ovfl), 32'(e.ovfl));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("zero", 32'(zero), 32'(e.zero));
                    chk("neg", 32'(neg), 32'(e.neg));
                    chk("in_ready_in_done", 32'(in_ready), 32'(0));
                    if (out_ready) void'(sb.pop_front());
                end
                prev_vld = 1'b1;
            end else begin
                prev_vld = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int acc0, acc1, acc2;
        int w;
        logic [W-1:0] corners [6];
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'hFFFF; corners[5] = 16'h8001;

        #3;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_flags", 32'({ovfl, cout, zero, neg}), 32'(0));
        step();
        rst_n = 1'b1;
        step();

        // Overflow and carry corners.
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc0); drain(1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0, acc0); drain(1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc0); drain(1'b0);
        issue(16'h0005, 16'h0005, 1'b1, 1'b0, acc0); drain(1'b0);

        // Backpressure with foreign in_valid pulses during RUN and DONE.
        out_ready = 1'b0;
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, acc0);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; in_valid = 1'b1;
        w = 0;
        while (!out_valid && w < 50) begin
            chk("in_ready_in_run", 32'(in_ready), 32'(0));
            step();
            w++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'(1));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("bp_released", 32'(out_valid), 32'(0));
        drain(1'b0);

        // Reset two digits into RUN: partial result must vanish.
        issue(16'h4321, 16'h1234, 1'b0, 1'b0, acc0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_sum", 32'(sum), 32'(0));
        chk("mid_rst_flags", 32'({ovfl, cout, zero, neg}), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        issue(16'h0003, 16'h0007, 1'b1, 1'b0, acc0); drain(1'b0);

        // Back-to-back with in_valid held high.
        issue(16'h0100, 16'h0023, 1'b0, 1'b1, acc0);
        issue(16'h9000, 16'h7000, 1'b1, 1'b1, acc1);
        issue(16'h7000, 16'h7000, 1'b0, 1'b0, acc2);
        chk("b2b_gap1", 32'(acc1 - acc0), 32'(NDIG + 2));
        chk("b2b_gap2", 32'(acc2 - acc1), 32'(NDIG + 2));
        drain(1'b0);

        // Random operations with random output backpressure.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0, acc0);
            drain(1'b1);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
